temp_mon_ctl: RTL and testbench



---
 rtl/temp_mon_pkg.sv | 22 ++
 rtl/temp_tick_gen.sv | 26 ++
 rtl/temp_mon_ctl.sv | 179 +++++++++++++++++
 tb/tb_temp_mon_ctl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_mon_pkg.sv
// Shared types and constants for the temperature monitor controller.
package temp_mon_pkg;

    localparam int unsigned TEMP_FRAC_BITS = 4;

    typedef logic signed [12:0] temp_t;

    typedef enum logic [1:0] {
        CUR = 2'd0,
        MIN = 2'd1,
        MAX = 2'd2,
        AVG = 2'd3
    } disp_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        UPDT = 2'd3
    } state_t;

endpackage

// File: rtl/temp_tick_gen.sv
// Free-running 0..SAMPLE_DIV-1 counter; tick_c is high during the terminal count cycle.
module temp_tick_gen #(
    parameter int unsigned SAMPLE_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_c
);

    localparam int unsigned CW = $clog2(SAMPLE_DIV);

    logic [CW-1:0] cnt;

    assign tick_c = (cnt == CW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/temp_mon_ctl.sv
// Sampling scheduler and current/min/max/average statistics for the temperature display path.
// Optional over-temperature alarm enabled by defining TEMP_ALARM_EN.
module temp_mon_ctl
    import temp_mon_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 100_000_000,
    parameter int unsigned AVG_LOG2   = 3,
    parameter int unsigned TW         = 13
`ifdef TEMP_ALARM_EN
    ,
    parameter logic signed [TW-1:0] ALARM_TH = 13'sd480
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] temp_i,
    input  logic          temp_vld_i,
    input  logic          err_i,
    input  logic          mode_btn_i,
    input  logic          clr_i,
    output logic [TW-1:0] temp_o,
    output logic [1:0]    mode_o,
    output logic          sample_o,
    output logic          stat_vld_o,
    output logic          avg_vld_o
`ifdef TEMP_ALARM_EN
    ,
    output logic          alarm_o
`endif
);

    localparam int unsigned AW = TW + AVG_LOG2;

    state_t               state;
    state_t               state_nxt;
    disp_mode_t           mode;
    logic                 tick_c;
    logic                 pending;
    logic signed [TW-1:0] cur;
    logic signed [TW-1:0] min_v;
    logic signed [TW-1:0] max_v;
    logic signed [TW-1:0] avg;
    logic signed [TW-1:0] disp_c;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_sum_c;
    logic [AVG_LOG2-1:0]  cnt;
    logic                 stat_vld;
    logic                 avg_vld;

    temp_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .tick_c(tick_c)
    );

    // A tick arriving while a request is already pending is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (state == CAPT) begin
            pending <= 1'b0;
        end else if (tick_c) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pending) state_nxt = WAIT;
            WAIT:    if (temp_vld_i && !err_i) state_nxt = CAPT;
            CAPT:    state_nxt = UPDT;
            UPDT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= '0;
            sample_o <= 1'b0;
        end else begin
            if (state == CAPT) cur <= $signed(temp_i);
            sample_o <= (state == UPDT);
        end
    end

    assign acc_sum_c = acc + AW'(cur);

    // Clear takes priority over a coinciding statistics update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_v    <= '0;
            max_v    <= '0;
            acc      <= '0;
            avg      <= '0;
            cnt      <= '0;
            stat_vld <= 1'b0;
            avg_vld  <= 1'b0;
`ifdef TEMP_ALARM_EN
            alarm_o  <= 1'b0;
`endif
        end else if (clr_i) begin
            min_v    <= '0;
            max_v    <= '0;
            acc      <= '0;
            avg      <= '0;
            cnt      <= '0;
            stat_vld <= 1'b0;
            avg_vld  <= 1'b0;
`ifdef TEMP_ALARM_EN
            alarm_o  <= 1'b0;
`endif
        end else if (state == UPDT) begin
            stat_vld <= 1'b1;
            if (!stat_vld) begin
                min_v <= cur;
                max_v <= cur;
            end else begin
                if (cur < min_v) min_v <= cur;
                if (cur > max_v) max_v <= cur;
            end
            cnt <= cnt + AVG_LOG2'(1);
            if (&cnt) begin
                avg     <= TW'(acc_sum_c >>> AVG_LOG2);
                acc     <= '0;
                avg_vld <= 1'b1;
            end else begin
                acc <= acc_sum_c;
            end
`ifdef TEMP_ALARM_EN
            if (cur > ALARM_TH) alarm_o <= 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= CUR;
        end else if (mode_btn_i) begin
            mode <= disp_mode_t'(2'(mode + 2'd1));
        end
    end

    // Statistics that are not yet valid display as zero.
    always_comb begin
        disp_c = cur;
        case (mode)
            CUR:     disp_c = cur;
            MIN:     disp_c = stat_vld ? min_v : '0;
            MAX:     disp_c = stat_vld ? max_v : '0;
            AVG:     disp_c = avg_vld ? avg : '0;
            default: disp_c = cur;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            temp_o <= '0;
        end else begin
            temp_o <= disp_c;
        end
    end

    assign mode_o     = mode;
    assign stat_vld_o = stat_vld;
    assign avg_vld_o  = avg_vld;

endmodule

// File: tb/tb_temp_mon_ctl.sv
// Self-checking bench for temp_mon_ctl against a sample-history reference model.
module tb_temp_mon_ctl;

    localparam int unsigned SD = 4;
    localparam int unsigned AL = 2;
    localparam int unsigned TW = 13;
    localparam int          WN = 1 << AL;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] temp_i;
    logic          temp_vld_i;
    logic          err_i;
    logic          mode_btn_i;
    logic          clr_i;
    logic [TW-1:0] temp_o;
    logic [1:0]    mode_o;
    logic          sample_o;
    logic          stat_vld_o;
    logic          avg_vld_o;
`ifdef TEMP_ALARM_EN
    logic          alarm_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int hist[$];
    int exp_cur = 0;

    temp_mon_ctl #(
        .SAMPLE_DIV(SD),
        .AVG_LOG2  (AL),
        .TW        (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .temp_i    (temp_i),
        .temp_vld_i(temp_vld_i),
        .err_i     (err_i),
        .mode_btn_i(mode_btn_i),
        .clr_i     (clr_i),
        .temp_o    (temp_o),
        .mode_o    (mode_o),
        .sample_o  (sample_o),
        .stat_vld_o(stat_vld_o),
        .avg_vld_o (avg_vld_o)
`ifdef TEMP_ALARM_EN
        ,
        .alarm_o   (alarm_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int sx(input logic [TW-1:0] v);
        return v[TW-1] ? int'(v) - (1 << TW) : int'(v);
    endfunction

    // Expected display value derived from the accepted-sample history since reset/clear.
    function automatic logic [TW-1:0] exp_disp(input int m);
        int w, s, r;
        if (m == 0) return TW'(exp_cur);
        if (m == 1 || m == 2) begin
            if (hist.size() == 0) return '0;
            r = hist[0];
            foreach (hist[i]) begin
                if (m == 1 && hist[i] < r) r = hist[i];
                if (m == 2 && hist[i] > r) r = hist[i];
            end
            return TW'(r);
        end
        w = hist.size() / WN;
        if (w == 0) return '0;
        s = 0;
        for (int i = 0; i < WN; i++) s += hist[(w - 1) * WN + i];
        r = (s - (((s % WN) + WN) % WN)) / WN;
        return TW'(r);
    endfunction

    function automatic logic exp_avg_vld();
        return (hist.size() >= WN);
    endfunction

    task automatic do_sample(input logic [TW-1:0] v);
        bit ok;
        ok = 0;
        temp_i = v;
        temp_vld_i = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (sample_o) ok = 1;
        end
        temp_vld_i = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sample_timeout: no sample_o for %h, required a pulse within 40 cycles", v);
        end else begin
            hist.push_back(sx(v));
            exp_cur = sx(v);
        end
    endtask

    task automatic goto_mode(input int m, output logic [TW-1:0] t);
        for (int i = 0; i < 4 && int'(mode_o) != m; i++) begin
            mode_btn_i = 1'b1;
            @(negedge clk);
            mode_btn_i = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        t = temp_o;
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        hist.delete();
    endtask

    task automatic test_reset();
        logic [6:0] got;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        got = {temp_o != 0, mode_o, sample_o, stat_vld_o, avg_vld_o};
        n_tests++;
        if (got !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b, required 0000000", got);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_sample();
        do_sample(13'h0190);
        n_tests++;
        if (temp_o !== 13'h0190 || mode_o !== 2'd0) begin
            n_fail++;
            $display("FAIL first_cur: temp_o %h mode %0d, required 0190 mode 0", temp_o, mode_o);
        end
        n_tests++;
        if (stat_vld_o !== 1'b1 || avg_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL first_vld: stat %b avg %b, required 1 0", stat_vld_o, avg_vld_o);
        end
    endtask

    task automatic test_stats();
        logic [TW-1:0] vals[3] = '{13'h1FB0, 13'h0200, 13'h0000};
        logic [TW-1:0] t;
        foreach (vals[i]) do_sample(vals[i]);
        n_tests++;
        if (avg_vld_o !== exp_avg_vld()) begin
            n_fail++;
            $display("FAIL stats_avg_vld: got %b, required %b", avg_vld_o, exp_avg_vld());
        end
        for (int m = 1; m < 4; m++) begin
            goto_mode(m, t);
            n_tests++;
            if (t !== exp_disp(m)) begin
                n_fail++;
                $display("FAIL stats_mode%0d: got %h, required %h", m, t, exp_disp(m));
            end
        end
    endtask

    task automatic test_random();
        logic [TW-1:0] t;
        pulse_clr();
        n_tests++;
        if (stat_vld_o !== 1'b0 || avg_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_vld: stat %b avg %b, required 0 0", stat_vld_o, avg_vld_o);
        end
        // negative window exercises rounding toward -inf: sum -5 -> -2
        do_sample(13'h1FFF);
        do_sample(13'h1FFF);
        do_sample(13'h1FFF);
        do_sample(13'h1FFE);
        for (int k = 0; k < 12; k++) begin
            do_sample(TW'($urandom_range(0, (1 << TW) - 1)));
            if (k % 3 == 2) begin
                for (int m = 0; m < 4; m++) begin
                    goto_mode(m, t);
                    n_tests++;
                    if (t !== exp_disp(m)) begin
                        n_fail++;
                        $display("FAIL rand_mode%0d: got %h, required %h", m, t, exp_disp(m));
                    end
                end
                n_tests++;
                if (avg_vld_o !== exp_avg_vld()) begin
                    n_fail++;
                    $display("FAIL rand_avg_vld: got %b, required %b", avg_vld_o, exp_avg_vld());
                end
            end
        end
    endtask

    task automatic test_err_stall();
        int pulses;
        logic [TW-1:0] t;
        logic [TW-1:0] v;
        v = 13'h0155;
        temp_i = v;
        err_i = 1'b1;
        temp_vld_i = 1'b1;
        pulses = 0;
        repeat (4 * SD) begin
            @(negedge clk);
            if (sample_o) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL err_stall: got %0d pulses during error, required 0", pulses);
        end
        err_i = 1'b0;
        pulses = 0;
        repeat (4 * SD) begin
            @(negedge clk);
            if (sample_o) begin
                pulses++;
                temp_vld_i = 1'b0;
            end
        end
        temp_vld_i = 1'b0;
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL err_release: got %0d pulses after release, required 1", pulses);
        end
        if (pulses > 0) begin
            hist.push_back(sx(v));
            exp_cur = sx(v);
        end
        goto_mode(0, t);
        n_tests++;
        if (t !== exp_disp(0)) begin
            n_fail++;
            $display("FAIL err_cur: got %h, required %h", t, exp_disp(0));
        end
    endtask

    task automatic test_mode_cycle();
        logic [TW-1:0] t;
        logic [TW-1:0] prev;
        goto_mode(0, t);
        for (int k = 1; k <= 4; k++) begin
            prev = exp_disp((k - 1) % 4);
            mode_btn_i = 1'b1;
            @(negedge clk);
            mode_btn_i = 1'b0;
            n_tests++;
            if (int'(mode_o) != k % 4 || temp_o !== prev) begin
                n_fail++;
                $display("FAIL mode_step%0d: mode %0d temp %h, required mode %0d temp %h",
                         k, mode_o, temp_o, k % 4, prev);
            end
            @(negedge clk);
            n_tests++;
            if (temp_o !== exp_disp(k % 4)) begin
                n_fail++;
                $display("FAIL mode_follow%0d: got %h, required %h", k, temp_o, exp_disp(k % 4));
            end
        end
    endtask

    task automatic test_clr_updt();
        logic [TW-1:0] t;
        logic [TW-1:0] v;
        v = TW'($urandom_range(1, 4000));
        goto_mode(0, t);
        repeat (3 * SD) @(negedge clk);
        temp_i = v;
        temp_vld_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr_i = 1'b1;
        mode_btn_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        mode_btn_i = 1'b0;
        temp_vld_i = 1'b0;
        hist.delete();
        exp_cur = sx(v);
        n_tests++;
        if (sample_o !== 1'b1 || stat_vld_o !== 1'b0 || avg_vld_o !== 1'b0 || mode_o !== 2'd1) begin
            n_fail++;
            $display("FAIL clr_updt: sample %b stat %b avg %b mode %0d, required 1 0 0 1",
                     sample_o, stat_vld_o, avg_vld_o, mode_o);
        end
        @(negedge clk);
        n_tests++;
        if (temp_o !== 13'h0000) begin
            n_fail++;
            $display("FAIL clr_min_placeholder: got %h, required 0000", temp_o);
        end
        goto_mode(0, t);
        n_tests++;
        if (t !== TW'(exp_cur)) begin
            n_fail++;
            $display("FAIL clr_cur: got %h, required %h", t, v);
        end
        do_sample(13'h0123);
        for (int m = 1; m < 3; m++) begin
            goto_mode(m, t);
            n_tests++;
            if (t !== 13'h0123) begin
                n_fail++;
                $display("FAIL clr_reload_mode%0d: got %h, required 0123", m, t);
            end
        end
    endtask

    task automatic test_reset_wait();
        logic [6:0] got;
        logic [TW-1:0] t;
        int lat;
        goto_mode(2, t);
        repeat (3 * SD) @(negedge clk);
        temp_i = 13'h0100;
        rst = 1'b1;
        #1;
        got = {temp_o != 0, mode_o, sample_o, stat_vld_o, avg_vld_o};
        n_tests++;
        if (got !== 7'd0) begin
            n_fail++;
            $display("FAIL rst_in_wait: got %b, required 0000000", got);
        end
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        exp_cur = 0;
        temp_vld_i = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (sample_o) lat = i;
        end
        temp_vld_i = 1'b0;
        n_tests++;
        if (lat < int'(SD) + 3 || lat > int'(SD) + 5) begin
            n_fail++;
            $display("FAIL rst_latency: got %0d cycles, required %0d..%0d", lat, SD + 3, SD + 5);
        end
        if (lat != 0) begin
            hist.push_back(sx(13'h0100));
            exp_cur = sx(13'h0100);
        end
`ifdef TEMP_ALARM_EN
        n_tests++;
        if (alarm_o !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_below: got %b, required 0", alarm_o);
        end
        do_sample(13'h01F0);
        n_tests++;
        if (alarm_o !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_set: got %b, required 1", alarm_o);
        end
        do_sample(13'h0000);
        n_tests++;
        if (alarm_o !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_sticky: got %b, required 1", alarm_o);
        end
        pulse_clr();
        n_tests++;
        if (alarm_o !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_clr: got %b, required 0", alarm_o);
        end
`endif
        goto_mode(0, t);
        n_tests++;
        if (t !== exp_disp(0)) begin
            n_fail++;
            $display("FAIL rst_next_cur: got %h, required %h", t, exp_disp(0));
        end
    endtask

    initial begin
        rst        = 1'b1;
        temp_i     = '0;
        temp_vld_i = 1'b0;
        err_i      = 1'b0;
        mode_btn_i = 1'b0;
        clr_i      = 1'b0;
        test_reset();
        test_first_sample();
        test_stats();
        test_random();
        test_err_stall();
        test_mode_cycle();
        test_clr_updt();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
